// File: rtl/rect_plotter.sv
// Rectangle rasteriser: turns one box request into a stream of one pixel per clock,
// filled or outline-only, with an erase colour override and per-pixel screen clipping.
module rect_plotter #(
  parameter int unsigned X_WIDTH         = 8,
  parameter int unsigned Y_WIDTH         = 7,
  parameter int unsigned COLOUR_WIDTH    = 6,
  parameter int unsigned X_SCREEN_PIXELS = 160,
  parameter int unsigned Y_SCREEN_PIXELS = 120,
  parameter logic [COLOUR_WIDTH-1:0] ERASE_COLOUR = '1
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic                    iGo,
  input  logic                    iErase,
  input  logic                    iMode,
  input  logic [X_WIDTH-1:0]      iX,
  input  logic [Y_WIDTH-1:0]      iY,
  input  logic [X_WIDTH-1:0]      iW,
  input  logic [Y_WIDTH-1:0]      iH,
  input  logic [COLOUR_WIDTH-1:0] iColour,
  output logic [X_WIDTH-1:0]      oX,
  output logic [Y_WIDTH-1:0]      oY,
  output logic [COLOUR_WIDTH-1:0] oColour,
  output logic                    oPlot,
  output logic                    oBusy,
  output logic                    oDone
);

  typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

  localparam logic [X_WIDTH:0] XLimit = X_SCREEN_PIXELS[X_WIDTH:0];
  localparam logic [Y_WIDTH:0] YLimit = Y_SCREEN_PIXELS[Y_WIDTH:0];

  state_e                  state_q, state_d;
  logic [X_WIDTH-1:0]      x0_q, x0_d, w_q, w_d, cx_q, cx_d;
  logic [Y_WIDTH-1:0]      y0_q, y0_d, h_q, h_d, cy_q, cy_d;
  logic                    mode_q, mode_d;
  logic [COLOUR_WIDTH-1:0] col_q, col_d;
  logic [X_WIDTH-1:0]      ox_q, ox_d;
  logic [Y_WIDTH-1:0]      oy_q, oy_d;
  logic [COLOUR_WIDTH-1:0] ocol_q, ocol_d;
  logic                    plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  logic [X_WIDTH-1:0] w_last, cx_nxt;
  logic [Y_WIDTH-1:0] h_last, cy_nxt;
  logic               row_edge, box_last;
  logic [X_WIDTH:0]   pix_x;
  logic [Y_WIDTH:0]   pix_y;

  // Counters always hold the pixel currently on the outputs; cx_nxt/cy_nxt is the next one.
  assign w_last   = w_q - X_WIDTH'(1);
  assign h_last   = h_q - Y_WIDTH'(1);
  assign row_edge = (cy_q == '0) || (cy_q == h_last);
  assign box_last = (cx_q == w_last) && (cy_q == h_last);

  always_comb begin
    cx_nxt = cx_q + X_WIDTH'(1);
    cy_nxt = cy_q;
    if (cx_q == w_last) begin
      cx_nxt = '0;
      cy_nxt = cy_q + Y_WIDTH'(1);
    end else if (mode_q && !row_edge && (cx_q == '0)) begin
      cx_nxt = w_last;
    end
  end

  // One bit wider than the ports so positions past the screen edge clip instead of wrapping.
  assign pix_x = {1'b0, x0_q} + {1'b0, cx_nxt};
  assign pix_y = {1'b0, y0_q} + {1'b0, cy_nxt};

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    mode_d  = mode_q;
    col_d   = col_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    ocol_d  = ocol_q;
    plot_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (iGo) begin
          x0_d   = iX;
          y0_d   = iY;
          w_d    = iW;
          h_d    = iH;
          mode_d = iMode;
          col_d  = iErase ? ERASE_COLOUR : iColour;
          cx_d   = '0;
          cy_d   = '0;
          busy_d = 1'b1;
          if ((iW == '0) || (iH == '0)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StDraw;
            ox_d    = iX;
            oy_d    = iY;
            ocol_d  = iErase ? ERASE_COLOUR : iColour;
            plot_d  = ({1'b0, iX} < XLimit) && ({1'b0, iY} < YLimit);
          end
        end
      end
      StDraw: begin
        if (box_last) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          cx_d   = cx_nxt;
          cy_d   = cy_nxt;
          ox_d   = pix_x[X_WIDTH-1:0];
          oy_d   = pix_y[Y_WIDTH-1:0];
          plot_d = (pix_x < XLimit) && (pix_y < YLimit);
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= StIdle;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      mode_q  <= 1'b0;
      col_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      ocol_q  <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      mode_q  <= mode_d;
      col_q   <= col_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      ocol_q  <= ocol_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oX      = ox_q;
  assign oY      = oy_q;
  assign oColour = ocol_q;
  assign oPlot   = plot_q;
  assign oBusy   = busy_q;
  assign oDone   = done_q;

endmodule
